// File: rtl/alu_issue.sv
// Two-stage issue/capture unit in front of the ALU: operand register S1, result register S2.
// Optional result forwarding into operand A is built when ALU_ISSUE_FWD_EN is defined.
module alu_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_fwd_a,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] OP_ILLEGAL = 3'b101;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_a_q, s1_a_d;
    logic [31:0]      s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_err_q, s1_err_d;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_result_q, s2_result_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_err_q, s2_err_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic        s2_free;
    logic        s1_adv;
    logic        accept;
    logic        deliver;
    logic [31:0] a_sel;

    assign s2_free  = !s2_valid_q | out_ready;
    assign s1_adv   = s1_valid_q & s2_free;
    assign in_ready = !s1_valid_q | s2_free;
    assign accept   = in_valid & in_ready;
    assign deliver  = s2_valid_q & out_ready;

`ifdef ALU_ISSUE_FWD_EN
    logic [31:0] fwd_q, fwd_d;
    logic [31:0] fwd_val;

    // A result handed off this very cycle is newer than fwd_q.
    assign fwd_val = deliver ? s2_result_q : fwd_q;
    assign a_sel   = in_fwd_a ? fwd_val : in_a;

    always_comb begin
        fwd_d = fwd_q;
        if (deliver) begin
            fwd_d = s2_result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q <= '0;
        end else begin
            fwd_q <= fwd_d;
        end
    end
`else
    logic unused_fwd_a;

    assign unused_fwd_a = in_fwd_a;
    assign a_sel        = in_a;
`endif

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        s1_err_d   = s1_err_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a_sel;
            s1_b_d     = in_b;
            s1_tag_d   = in_tag;
            s1_err_d   = (in_op == OP_ILLEGAL);
            // The ALU must never be driven with the illegal encoding.
            s1_op_d    = (in_op == OP_ILLEGAL) ? 3'b000 : in_op;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_zero_d   = s2_zero_q;
        s2_err_d    = s2_err_q;
        s2_tag_d    = s2_tag_q;
        if (s1_adv) begin
            s2_valid_d  = 1'b1;
            s2_result_d = s1_err_q ? 32'd0 : alu_result;
            s2_zero_d   = s1_err_q ? 1'b0 : alu_zero;
            s2_err_d    = s1_err_q;
            s2_tag_d    = s1_tag_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_tag_q    <= '0;
            s1_err_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zero_q   <= 1'b0;
            s2_err_q    <= 1'b0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s1_err_q    <= s1_err_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_zero_q   <= s2_zero_d;
            s2_err_q    <= s2_err_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign alu_a      = s1_a_q;
    assign alu_b      = s1_b_q;
    assign alu_op     = s1_op_q;
    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_zero   = s2_zero_q;
    assign out_err    = s2_err_q;
    assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a behavioural ALU on the alu_* port.
// Forwarding expectations follow ALU_ISSUE_FWD_EN.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic [4:0]  in_tag;
    logic        in_fwd_a;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_err;
    logic [4:0]  out_tag;

    int checks   = 0;
    int failures = 0;
    int bad_op   = 0;

    always #5 clk = ~clk;

    alu_issue #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_tag(in_tag), .in_fwd_a(in_fwd_a),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_err(out_err), .out_tag(out_tag)
    );

    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b110: alu_result = alu_a << alu_b[4:0];
            3'b111: alu_result = alu_a >> alu_b[4:0];
            default: alu_result = 32'hdead_beef;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    always @(negedge clk) begin
        if (alu_op == 3'b101) bad_op++;
    end

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op,
                         input logic [4:0] tag, input logic fwd);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
        in_fwd_a = fwd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0);
        step();
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_result !== 32'd0 || out_zero !== 1'b0 || out_err !== 1'b0 || out_tag !== 5'd0) begin
            failures++;
            $display("FAIL reset_out res=%0d z=%b e=%b tag=%0d exp all 0", out_result, out_zero, out_err, out_tag);
        end
        checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'b000) begin
            failures++;
            $display("FAIL reset_alu a=%0d b=%0d op=%0d exp 0", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 32'd5, 32'd10, 3'b000, 5'd9, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0);
        checks++;
        if (alu_a !== 32'd5 || alu_b !== 32'd10 || alu_op !== 3'b000 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_s1 a=%0d b=%0d op=%0d ov=%b exp 5/10/0/0", alu_a, alu_b, alu_op, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd15 || out_zero !== 1'b0 || out_err !== 1'b0 || out_tag !== 5'd9) begin
            failures++;
            $display("FAIL single_out v=%b res=%0d z=%b e=%b tag=%0d exp 1/15/0/0/9", out_valid, out_result, out_zero, out_err, out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] va [6] = '{32'd10, 32'd5, 32'd5, 32'd5, 32'd5, 32'd4};
        logic [31:0] vb [6] = '{32'd5, 32'd3, 32'd3, 32'd3, 32'd2, 32'd2};
        logic [2:0]  vo [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
        logic [31:0] ex [6] = '{32'd5, 32'd1, 32'd7, 32'd6, 32'd20, 32'd1};
        for (int i = 0; i < 7; i++) begin
            if (i < 6) drive(1'b1, va[i], vb[i], vo[i], 5'(i + 1), 1'b0);
            else drive(1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready[%0d] in_ready=%b exp 1", i, in_ready);
            end
            step();
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== ex[i-1] || out_tag !== 5'(i)) begin
                    failures++;
                    $display("FAIL stream_out[%0d] v=%b res=%0d tag=%0d exp 1/%0d/%0d", i - 1, out_valid, out_result, out_tag, ex[i-1], i);
                end
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd1, 3'b000, 5'd1, 1'b0);
        step();
        drive(1'b1, 32'd9, 32'd4, 3'b001, 5'd2, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second_ready in_ready=%b exp 1", in_ready);
        end
        step();
        drive(1'b1, 32'd8, 32'd1, 3'b011, 5'd3, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd2) begin
            failures++;
            $display("FAIL bp_full in_ready=%b ov=%b res=%0d exp 0/1/2", in_ready, out_valid, out_result);
        end
        step();
        checks++;
        if (in_ready !== 1'b0 || out_result !== 32'd2 || out_tag !== 5'd1 || alu_a !== 32'd9) begin
            failures++;
            $display("FAIL bp_hold in_ready=%b res=%0d tag=%0d alu_a=%0d exp 0/2/1/9", in_ready, out_result, out_tag, alu_a);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release in_ready=%b exp 1", in_ready);
        end
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd5 || out_tag !== 5'd2) begin
            failures++;
            $display("FAIL bp_out1 v=%b res=%0d tag=%0d exp 1/5/2", out_valid, out_result, out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd9 || out_tag !== 5'd3) begin
            failures++;
            $display("FAIL bp_out2 v=%b res=%0d tag=%0d exp 1/9/3", out_valid, out_result, out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_illegal_zero();
        drive(1'b1, 32'd7, 32'd7, 3'b101, 5'd4, 1'b0);
        step();
        drive(1'b1, 32'd0, 32'd0, 3'b000, 5'd5, 1'b0);
        checks++;
        if (alu_op !== 3'b000) begin
            failures++;
            $display("FAIL illegal_alu_op alu_op=%0d exp 0", alu_op);
        end
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b0 || out_tag !== 5'd4) begin
            failures++;
            $display("FAIL illegal_out v=%b e=%b res=%0d z=%b tag=%0d exp 1/1/0/0/4", out_valid, out_err, out_result, out_zero, out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_err !== 1'b0 || out_result !== 32'd0 || out_tag !== 5'd5) begin
            failures++;
            $display("FAIL zero_out v=%b z=%b e=%b res=%0d tag=%0d exp 1/1/0/0/5", out_valid, out_zero, out_err, out_result, out_tag);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(1'b1, 32'd2, 32'd2, 3'b000, 5'd6, 1'b0);
        step();
        drive(1'b1, 32'd3, 32'd3, 3'b000, 5'd7, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 32'd0 || out_result !== 32'd0) begin
            failures++;
            $display("FAIL midrst v=%b rdy=%b alu_a=%0d res=%0d exp 0/1/0/0", out_valid, in_ready, alu_a, out_result);
        end
        out_ready = 1'b1;
        drive(1'b1, 32'd3, 32'd4, 3'b000, 5'd8, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ghost out_valid=%b exp 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd7 || out_tag !== 5'd8) begin
            failures++;
            $display("FAIL midrst_next v=%b res=%0d tag=%0d exp 1/7/8", out_valid, out_result, out_tag);
        end
        step();
    endtask

    task automatic test_forward();
        logic [31:0] exp1, exp2;
`ifdef ALU_ISSUE_FWD_EN
        exp1 = 32'd16;
        exp2 = 32'd17;
`else
        exp1 = 32'd1;
        exp2 = 32'd1;
`endif
        drive(1'b1, 32'd5, 32'd10, 3'b000, 5'd10, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0);
        step();
        checks++;
        if (out_result !== 32'd15) begin
            failures++;
            $display("FAIL fwd_src res=%0d exp 15", out_result);
        end
        step();
        drive(1'b1, 32'd0, 32'd1, 3'b000, 5'd11, 1'b1);
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp1) begin
            failures++;
            $display("FAIL fwd_reg v=%b res=%0d exp 1/%0d", out_valid, out_result, exp1);
        end
        drive(1'b1, 32'd0, 32'd1, 3'b000, 5'd12, 1'b1);
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp2 || out_tag !== 5'd12) begin
            failures++;
            $display("FAIL fwd_bypass v=%b res=%0d tag=%0d exp 1/%0d/12", out_valid, out_result, out_tag, exp2);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_illegal_zero();
        test_reset_midflight();
        test_forward();
        checks++;
        if (bad_op !== 0) begin
            failures++;
            $display("FAIL alu_op_101 seen=%0d exp 0", bad_op);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue/capture unit that sits on the initiator side of the ALU port. It accepts decoded operations over a valid/ready handshake, registers operands and drives them onto the ALU's `a`/`b`/`op` inputs. It then captures the ALU `result`/`zeroFlag` into a result register and presents them downstream over a second valid/ready handshake. It is a two-stage pipeline with full throughput, backpressure, illegal-op detection and optional result forwarding.

## Interface
Parameters:
- `TAG_W`, default 5: width of the destination-register tag carried alongside each op.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream op is present.
- `in_ready`  out  1  block can accept an op this cycle.
- `in_a`, `in_b`  in  32  operands.
- `in_op`  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 110 sll, 111 srl; 101 is illegal.
- `in_tag`  in  TAG_W  destination tag.
- `in_fwd_a`  in  1  replace `in_a` with the last delivered result (see Configuration).
- `alu_a`, `alu_b`  out  32  operands driven to the ALU.
- `alu_op`  out  3  op driven to the ALU.
- `alu_result`  in  32  combinational ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_result`  out  32  captured result.
- `out_zero`  out  1  captured zero flag.
- `out_err`  out  1  captured op was illegal.
- `out_tag`  out  TAG_W  tag of the captured op.

## Operation
- Stage S1 (operand register): `s1_valid`, `s1_a`, `s1_b`, `s1_op`, `s1_tag`, `s1_err`. The `alu_*` outputs are driven directly from the S1 registers.
- Stage S2 (result register): `s2_valid` and the `out_*` registers.
- The S2 handshake outputs are registered. `out_valid` equals `s2_valid`. `out_result`, `out_zero`, `out_err` and `out_tag` equal the S2 registers.
- Advance conditions:
  - `s2_free = !s2_valid | out_ready`
  - `s1_adv = s1_valid & s2_free`
  - `in_ready = !s1_valid | s2_free`
  - `in_ready` is combinational from `out_ready`; no skid buffer.
- Accept (`in_valid & in_ready`): S1 loads the operands, op, tag and `s1_err = (in_op == 101)`. `s1_valid` is set to 1.
- No accept but `s1_adv`: `s1_valid` is cleared to 0.
- Illegal op:
  - S1 stores op 000 so the ALU never sees 101.
  - On advance, S2 captures `out_result = 0`, `out_zero = 0`, `out_err = 1`.
- Legal op on advance: S2 captures `alu_result` and `alu_zero`, with `out_err = 0`.
- S2 update rules:
  - `s2_valid` becomes 1 on `s1_adv`.
  - Otherwise `s2_valid` clears when `out_ready` is high.
  - While `out_valid & !out_ready`, the S2 contents hold stable.
- Simultaneous events: accepting into S1 while S1 advances into S2 and S2 delivers downstream is one cycle with no bubble.
- Operands pass unmodified. Shift-amount interpretation belongs to the ALU.
- Ops retire in order; there is no reordering and no drop.

## Timing
- Reset values:
  - `s1_valid = 0` and `s2_valid = 0`.
  - All data registers = 0.
  - Outputs: `in_ready = 1`, `out_valid = 0`, `out_result = 0`, `out_zero = 0`, `out_err = 0`, `out_tag = 0`, `alu_a = 0`, `alu_b = 0`, `alu_op = 000`.
  - Forwarding register = 0.
- Latency: an op accepted at edge N drives the ALU during cycle N..N+1 and appears on `out_*` with `out_valid = 1` after edge N+1. That is 2 cycles, given no backpressure.
- Throughput: one op per cycle while `out_ready` is held high.
- Full: with S1 and S2 both valid and `out_ready = 0`, `in_ready = 0`. At most 2 ops are in flight.
- Reset mid-operation: all in-flight ops are discarded and no `out_valid` is produced for them. The first cycle after reset is identical to post-reset idle.

## Configuration
- `ALU_ISSUE_FWD_EN`:
  - Defined:
    - A 32-bit register `fwd_q` loads `out_result` on every downstream handshake (`out_valid & out_ready`).
    - On accept with `in_fwd_a = 1`, S1 loads `s1_a` from the forwarded value instead of `in_a`.
    - If a handshake occurs in the same cycle as the accept, the forwarded value is the `out_result` being delivered.
    - Otherwise the forwarded value is `fwd_q`.
    - `fwd_q` resets to 0.
  - Undefined: `in_fwd_a` is ignored, `s1_a` always loads `in_a`, and no `fwd_q` register exists.

## Test plan
- Reset then a single op: `a=5, b=10, op=000` with `out_ready = 1` -> two cycles later `out_valid = 1`, `out_result = 15`, `out_zero = 0`, `out_err = 0`, `out_tag` equal to the input tag. `alu_op` saw 000.
- Streaming: back-to-back sub `10-5`, and `5&3`, or `5|3`, xor `5^3`, sll `5<<2`, srl `4>>2` -> results 5, 1, 7, 6, 20, 1 on six consecutive cycles, in order.
- Backpressure: `out_ready = 0` while 3 ops are offered -> 2 accepted, then `in_ready = 0`. Raising `out_ready` delivers all 3 in order with no loss or duplication.
- Illegal/zero: op 101 with `a = 7, b = 7` -> `out_err = 1`, `out_result = 0`, and `alu_op` never equals 101. Add `0+0` -> `out_zero = 1`, `out_err = 0`.
- Reset mid-flight: 2 ops in flight, assert `rst` for one cycle -> `out_valid = 0` and `in_ready = 1` afterwards. The next op completes normally.
- With `ALU_ISSUE_FWD_EN`: `5+10` is delivered, then `in_fwd_a = 1, in_b = 1, op = 000` -> result 16. Without the macro, the same stimulus with `in_a = 0` -> result 1.
